sort_result_reader: RTL and testbench

Read-side companion to the heap sorter: after the sorter signals completion, this block fetches the 16 sorted bytes from the result RAM over its synchronous read port and streams them out on a valid/ready byte interface. While streaming, it checks the sort order and accumulates a checksum, so downstream logic and benches get a self-checked result. It sits between the result RAM read port and whichever consumer needs the sorted list.

---
 rtl/sort_pkg.sv | 29 ++
 rtl/sort_skid_fifo.sv | 63 ++++++
 rtl/sort_result_reader.sv | 166 ++++++++++++++++
 tb/tb_sort_result_reader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the heap sorter result path: default geometry,
// reader state encoding and the sort-order check used by reader and benches.
package sort_pkg;

  localparam int SORT_DEPTH = 16;
  localparam int SORT_AW    = 4;
  localparam int SORT_DW    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } reader_state_t;

  // True when cur_b breaks the required order relative to prev_b.
  // Equal neighbours never count as a violation.
  function automatic logic order_violation(input logic [SORT_DW-1:0] prev_b,
                                           input logic [SORT_DW-1:0] cur_b,
                                           input logic               descend);
    logic bad;
    if (descend) begin
      bad = (cur_b > prev_b);
    end else begin
      bad = (cur_b < prev_b);
    end
    return bad;
  endfunction

endpackage

// File: rtl/sort_skid_fifo.sv
// Two-entry FIFO that absorbs RAM read data while the consumer stalls.
// The head entry is visible combinationally from the storage registers.
module sort_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push_s, do_pop_s;

  // Next-state for storage, pointers and occupancy; a push into a full
  // FIFO is only honoured when the same cycle pops.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    do_pop_s  = pop_i && (count_q != 2'd0);
    do_push_s = push_i && ((count_q != 2'd2) || do_pop_s);
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
  end

  // FIFO state registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= {W{1'b0}};
      mem_q[1] <= {W{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sort_result_reader.sv
// Streams the sorted result RAM out on a valid/ready byte interface once the
// sorter reports completion, checking order and summing accepted bytes.
module sort_result_reader
  import sort_pkg::*;
#(
  parameter int DEPTH   = SORT_DEPTH,
  parameter int AW      = SORT_AW,
  parameter int DW      = SORT_DW,
  parameter int DESCEND = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sort_done,
  output logic             RAM_rd,
  output logic [AW-1:0]    RAM_A,
  input  logic [DW-1:0]    RAM_Q,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [DW+AW-1:0] sum,
  output logic             order_err,
  output logic             done
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH-1);

  reader_state_t     state_q, state_d;
  logic              armed_q, armed_d;
  logic [AW:0]       rd_cnt_q, rd_cnt_d;
  logic [AW:0]       snd_cnt_q, snd_cnt_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [DW+AW-1:0]  sum_q, sum_d;
  logic              order_err_q, order_err_d;
  logic [DW-1:0]     prev_q, prev_d;

  logic [1:0]        fifo_count_s;
  logic [DW:0]       fifo_head_s;
  logic              fifo_valid_s;
  logic              hs_s;
  logic [1:0]        buffered_s;
  logic              rd_room_s;
  logic              rd_issue_s;
  logic [DW-1:0]     head_data_s;
  logic              head_last_s;

  sort_skid_fifo #(.W(DW+1)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, RAM_Q}),
    .pop_i       (hs_s),
    .count_o     (fifo_count_s),
    .head_o      (fifo_head_s)
  );

  assign fifo_valid_s = (fifo_count_s != 2'd0);
  assign head_data_s  = fifo_head_s[DW-1:0];
  assign head_last_s  = fifo_head_s[DW];
  assign hs_s         = fifo_valid_s & out_ready;
  // Entries that stay buffered past this edge plus the read returning now
  // must leave a free slot for a read issued this cycle.
  assign buffered_s   = fifo_count_s - {1'b0, hs_s};
  assign rd_room_s    = (({1'b0, buffered_s} + {2'b00, inflight_q}) < 3'd2);
  assign rd_issue_s   = (state_q == STREAM) && (rd_cnt_q < DEPTH_C) && rd_room_s;

  // FSM next state, read/send counters, checksum and order check.
  always_comb begin
    state_d         = state_q;
    armed_d         = armed_q;
    rd_cnt_d        = rd_cnt_q;
    snd_cnt_d       = snd_cnt_q;
    sum_d           = sum_q;
    order_err_d     = order_err_q;
    prev_d          = prev_q;
    inflight_d      = rd_issue_s;
    inflight_last_d = rd_issue_s && (rd_cnt_q[AW-1:0] == LAST_A);
    case (state_q)
      IDLE: begin
        if (sort_done && armed_q) begin
          state_d     = STREAM;
          armed_d     = 1'b0;
          rd_cnt_d    = {(AW+1){1'b0}};
          snd_cnt_d   = {(AW+1){1'b0}};
          sum_d       = {(DW+AW){1'b0}};
          order_err_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (rd_issue_s) begin
          rd_cnt_d = rd_cnt_q + (AW+1)'(1);
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
        if (hs_s) begin
          sum_d     = sum_q + {{AW{1'b0}}, head_data_s};
          prev_d    = head_data_s;
          snd_cnt_d = snd_cnt_q + (AW+1)'(1);
          if ((snd_cnt_q != {(AW+1){1'b0}}) &&
              order_violation(prev_q, head_data_s, DESCEND != 0)) begin
            order_err_d = 1'b1;
          end else begin
            order_err_d = order_err_q;
          end
          if (head_last_s) begin
            state_d = FINISH;
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = STREAM;
        end
      end
      FINISH: begin
        if (!sort_done) begin
          state_d = IDLE;
          armed_d = 1'b1;
        end else begin
          state_d = FINISH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset also drops any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      armed_q         <= 1'b1;
      rd_cnt_q        <= {(AW+1){1'b0}};
      snd_cnt_q       <= {(AW+1){1'b0}};
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      sum_q           <= {(DW+AW){1'b0}};
      order_err_q     <= 1'b0;
      prev_q          <= {DW{1'b0}};
    end else begin
      state_q         <= state_d;
      armed_q         <= armed_d;
      rd_cnt_q        <= rd_cnt_d;
      snd_cnt_q       <= snd_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      sum_q           <= sum_d;
      order_err_q     <= order_err_d;
      prev_q          <= prev_d;
    end
  end

  assign RAM_rd    = rd_issue_s;
  assign RAM_A     = rd_cnt_q[AW-1:0];
  assign out_valid = fifo_valid_s;
  assign out_data  = fifo_valid_s ? head_data_s : {DW{1'b0}};
  assign out_last  = fifo_valid_s & head_last_s;
  assign sum       = sum_q;
  assign order_err = order_err_q;
  assign done      = (state_q == FINISH);

endmodule

// File: tb/tb_sort_result_reader.sv
// Bench for sort_result_reader: a RAM model feeds the reader while the bench
// predicts the byte stream, checksum and order flag from the RAM contents.
module tb_sort_result_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        sort_done;
  logic        RAM_rd;
  logic [3:0]  RAM_A;
  logic [7:0]  RAM_Q = 8'd0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [11:0] sum;
  logic        order_err;
  logic        done;

  logic [7:0]  mem [16];
  int          total = 0;
  int          bad   = 0;

  sort_result_reader dut (
    .clk       (clk),
    .reset     (reset),
    .sort_done (sort_done),
    .RAM_rd    (RAM_rd),
    .RAM_A     (RAM_A),
    .RAM_Q     (RAM_Q),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sum       (sum),
    .order_err (order_err),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model: data appears one cycle after the read.
  always @(posedge clk) begin
    if (RAM_rd) RAM_Q <= mem[RAM_A];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd"},    32'(RAM_rd),    32'd0);
    chk({tag, "_addr"},  32'(RAM_A),     32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"},  32'(out_data),  32'd0);
    chk({tag, "_last"},  32'(out_last),  32'd0);
    chk({tag, "_sum"},   32'(sum),       32'd0);
    chk({tag, "_err"},   32'(order_err), 32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0, 2: random ready.
  // rst_at > 0 aborts the stream with reset in that cycle;
  // drop_at > 0 lowers sort_done in that cycle of the stream.
  task automatic run_stream(input int mode, input int rst_at, input int drop_at);
    int         idx = 0;
    int         issued = 0;
    int         accepted = 0;
    int         exp_sum = 0;
    int         c = 0;
    bit         exp_err = 1'b0;
    bit         held = 1'b0;
    bit         rdy;
    bit         hs;
    logic [7:0] held_d = 8'd0;
    logic       held_l = 1'b0;
    sort_done = 1'b1;
    out_ready = 1'b1;
    while (idx < 16 && c < 300) begin
      @(posedge clk); #1;
      c++;
      if (c == rst_at) begin
        reset = 1'b1;
        sort_done = 1'b0;
        @(posedge clk); #1;
        chk_reset("midrst");
        reset = 1'b0;
        return;
      end
      if (c == drop_at) sort_done = 1'b0;
      if (c == 1) begin
        chk("clr_sum", 32'(sum), 32'd0);
        chk("clr_err", 32'(order_err), 32'd0);
      end
      chk("run_sum", 32'(sum), 32'(exp_sum));
      chk("run_err", 32'(order_err), 32'(exp_err));
      chk("no_done", 32'(done), 32'd0);
      if (held) begin
        chk("hold_v", 32'(out_valid), 32'd1);
        chk("hold_d", 32'(out_data), 32'(held_d));
        chk("hold_l", 32'(out_last), 32'(held_l));
      end
      if (out_valid) begin
        chk("data", 32'(out_data), 32'(mem[idx]));
        chk("last", 32'(out_last), 32'(idx == 15));
        if (mode == 0) chk("slot", 32'(c), 32'(idx + 3));
      end else if (mode == 0 && c >= 3) begin
        chk("bubble", 32'(out_valid), 32'd1);
      end
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = ((c % 3) == 0);
      else                rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      #1;
      hs = out_valid && rdy;
      if (hs) accepted++;
      if (c == 1) chk("first_rd", 32'(RAM_rd), 32'd1);
      if (RAM_rd) begin
        chk("rd_addr", 32'(RAM_A), 32'(issued));
        chk("rd_room", 32'((issued - accepted) < 2), 32'd1);
        issued++;
      end
      if (hs) begin
        if (idx > 0 && mem[idx] < mem[idx-1]) exp_err = 1'b1;
        exp_sum += int'(mem[idx]);
        idx++;
        held = 1'b0;
      end else begin
        held   = out_valid;
        held_d = out_data;
        held_l = out_last;
      end
    end
    chk("complete", 32'(idx), 32'd16);
    @(posedge clk); #1;
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_sum", 32'(sum), 32'(exp_sum));
    chk("fin_err", 32'(order_err), 32'(exp_err));
    chk("fin_valid", 32'(out_valid), 32'd0);
    chk("fin_rd", 32'(RAM_rd), 32'd0);
    if (mode == 0) chk("done_slot", 32'(c + 1), 32'd19);
  endtask

  // Drop sort_done for one cycle so the reader re-arms and returns to IDLE.
  task automatic end_stream();
    sort_done = 1'b0;
    @(posedge clk); #1;
    chk("done_drop", 32'(done), 32'd0);
  endtask

  task automatic hold_finish(input int exp_sum);
    repeat (3) begin
      @(posedge clk); #1;
      chk("fin_hold", 32'(done), 32'd1);
      chk("fin_hold_sum", 32'(sum), 32'(exp_sum));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    reset     = 1'b1;
    sort_done = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    reset = 1'b0;
    @(posedge clk); #1;

    // Ascending data at full rate, then linger in FINISH.
    run_stream(0, -1, -1);
    hold_finish(120);
    end_stream();

    // Same data with a 1,0,0 ready pattern.
    run_stream(1, -1, -1);
    end_stream();

    // All 255: maximum checksum, equal neighbours are legal.
    for (int i = 0; i < 16; i++) mem[i] = 8'd255;
    run_stream(2, -1, -1);
    chk("sum_4080", 32'(sum), 32'd4080);
    end_stream();

    // Entries 7 and 8 swapped: order error sticks through FINISH.
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    mem[7] = 8'd8;
    mem[8] = 8'd7;
    run_stream(0, -1, -1);
    hold_finish(120);
    chk("swap_err_hold", 32'(order_err), 32'd1);
    end_stream();

    // Reset mid-stream, then a full stream from address 0 and a repeat.
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    run_stream(0, 9, -1);
    run_stream(0, -1, -1);
    end_stream();
    run_stream(0, -1, -1);
    end_stream();

    // Random ascending data, random ready, sort_done dropped mid-stream.
    mem[0] = 8'($urandom_range(0, 15));
    for (int i = 1; i < 16; i++) mem[i] = mem[i-1] + 8'($urandom_range(0, 15));
    run_stream(2, -1, 5);
    end_stream();

    // Fully random data with random ready.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
    run_stream(2, -1, -1);
    end_stream();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
